// File: rtl/hpc3_pkg.sv
// hpc3_pkg: shared constants and types for the HPC3 issue scheduler.
// Provides share geometry, randomness word layout (byte offsets of each
// rXY / pXY term inside rnd_data) and the packed share-vector type.
package hpc3_pkg;

  localparam int SHARE_W = 8;
  localparam int SHARES  = 5;
  localparam int NPAIR   = SHARES * (SHARES - 1) / 2;
  localparam int RND_W   = 2 * NPAIR * SHARE_W;

  // r terms occupy rnd_data[79:0], lowest byte first.
  localparam int R01_LSB = 0;
  localparam int R02_LSB = 8;
  localparam int R03_LSB = 16;
  localparam int R04_LSB = 24;
  localparam int R12_LSB = 32;
  localparam int R13_LSB = 40;
  localparam int R14_LSB = 48;
  localparam int R23_LSB = 56;
  localparam int R24_LSB = 64;
  localparam int R34_LSB = 72;
  // p terms follow in the same pair order.
  localparam int P_BASE  = NPAIR * SHARE_W;
  localparam int P01_LSB = P_BASE + R01_LSB;
  localparam int P34_LSB = P_BASE + R34_LSB;

  typedef logic [SHARES*SHARE_W-1:0] share_vec_t;

endpackage

// File: rtl/hpc3_res_fifo.sv
// hpc3_res_fifo: show-ahead result FIFO, WIDTH bits x DEPTH entries.
// Ports: clk/rst (sync, active high), wr_en/wr_data push, rd_en pop,
//        rd_data = head, empty, count = occupied entries.
module hpc3_res_fifo #(
  parameter int WIDTH = 41,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             rd_ok;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign rd_ok   = rd_en && (count_q != '0);
  assign rd_data = mem_q[rd_ptr_q];
  assign empty   = (count_q == '0);
  assign count   = count_q;

  // Storage is cleared on reset so the head reads as zero afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= wr_data;
        wr_ptr_q        <= ptr_next(wr_ptr_q);
      end
      if (rd_ok) rd_ptr_q <= ptr_next(rd_ptr_q);
      count_q <= count_q + CW'(wr_en) - CW'(rd_ok);
    end
  end

endmodule

// File: rtl/hpc3_issue_sched.sv
// hpc3_issue_sched: round-robin scheduler sharing one HPC3 masked AND gadget
// between two requesters. Ports: req0/req1 valid/ready/a/b, rnd valid/ready/
// data, gadget g_a/g_b/g_r/g_p out and g_c in, res valid/ready/id/c, busy.
// Optional macro HPC3_SCHED_ZEROIZE_EN forces gadget inputs to 0 when idle.
module hpc3_issue_sched
  import hpc3_pkg::*;
#(
  parameter int LAT       = 2,
  parameter int OUT_DEPTH = 4,
  parameter int SHARES    = 5
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              req0_valid,
  input  logic                              req1_valid,
  output logic                              req0_ready,
  output logic                              req1_ready,
  input  logic [SHARES*SHARE_W-1:0]         req0_a,
  input  logic [SHARES*SHARE_W-1:0]         req1_a,
  input  logic [SHARES*SHARE_W-1:0]         req0_b,
  input  logic [SHARES*SHARE_W-1:0]         req1_b,
  input  logic                              rnd_valid,
  output logic                              rnd_ready,
  input  logic [SHARES*(SHARES-1)*SHARE_W-1:0] rnd_data,
  output logic [SHARES*SHARE_W-1:0]         g_a,
  output logic [SHARES*SHARE_W-1:0]         g_b,
  output logic [SHARES*(SHARES-1)*SHARE_W/2-1:0] g_r,
  output logic [SHARES*(SHARES-1)*SHARE_W/2-1:0] g_p,
  input  logic [SHARES*SHARE_W-1:0]         g_c,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic                              res_id,
  output logic [SHARES*SHARE_W-1:0]         res_c,
  output logic                              busy
);

  localparam int VW = SHARES * SHARE_W;
  localparam int HW = SHARES * (SHARES - 1) * SHARE_W / 2;
  localparam int CW = $clog2(OUT_DEPTH + 1);

  logic           rr_q, rr_d;
  logic [LAT-1:0] trk_vld_q, trk_id_q;
  logic [CW-1:0]  fifo_cnt;
  logic           fifo_empty;
  logic           credit, issue, gnt, sel;
  logic [VW-1:0]  mux_a, mux_b;
  int             inflight;

  // Credit counts both queued results and ops still inside the gadget, so a
  // result slot is always reserved before the non-stallable pipeline is fed.
  always_comb begin
    inflight = 0;
    for (int i = 0; i < LAT; i++) begin
      if (trk_vld_q[i]) inflight++;
    end
    credit = (int'(fifo_cnt) + inflight) < OUT_DEPTH;
  end

  always_comb begin
    // With a single requester valid, grant it; rr only breaks ties.
    gnt   = (req0_valid && req1_valid) ? rr_q : !req0_valid;
    issue = (req0_valid || req1_valid) && rnd_valid && credit && !rst;
    sel   = issue ? gnt : rr_q;
    mux_a = sel ? req1_a : req0_a;
    mux_b = sel ? req1_b : req0_b;
    rr_d  = issue ? !gnt : rr_q;
  end

`ifdef HPC3_SCHED_ZEROIZE_EN
  assign g_a = issue ? mux_a : '0;
  assign g_b = issue ? mux_b : '0;
  assign g_r = issue ? rnd_data[HW-1:0] : '0;
  assign g_p = issue ? rnd_data[2*HW-1:HW] : '0;
`else
  assign g_a = mux_a;
  assign g_b = mux_b;
  assign g_r = rnd_data[HW-1:0];
  assign g_p = rnd_data[2*HW-1:HW];
`endif

  assign req0_ready = issue && !gnt;
  assign req1_ready = issue && gnt;
  assign rnd_ready  = issue;

  // Tracker mirrors the gadget pipeline; the last stage marks the cycle in
  // which g_c belongs to a real op and must be captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q      <= 1'b0;
      trk_vld_q <= '0;
      trk_id_q  <= '0;
    end else begin
      rr_q <= rr_d;
      for (int i = LAT - 1; i > 0; i--) begin
        trk_vld_q[i] <= trk_vld_q[i-1];
        trk_id_q[i]  <= trk_id_q[i-1];
      end
      trk_vld_q[0] <= issue;
      trk_id_q[0]  <= gnt;
    end
  end

  hpc3_res_fifo #(
    .WIDTH(VW + 1),
    .DEPTH(OUT_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (trk_vld_q[LAT-1]),
    .wr_data({trk_id_q[LAT-1], g_c}),
    .rd_en  (res_valid && res_ready),
    .rd_data({res_id, res_c}),
    .empty  (fifo_empty),
    .count  (fifo_cnt)
  );

  assign res_valid = !fifo_empty;
  assign busy      = (|trk_vld_q) || !fifo_empty;

endmodule
